test_pattern_generator: RTL and testbench

- Parametrised successor to the fixed four-pattern Bayer image generator feeding the CSI-2 packetiser.
- Takes the raster coordinates from the line/pixel timing logic and produces one Bayer quad per pixel: R, Gr, Gb, B.
- Supports eight pattern modes, including a frame-animated moving bar.
- Pattern is either auto-cycled every N frames or host-selected, and switches only on frame boundaries.
- Two-stage registered pipeline with a valid flag.

---
 rtl/tpg_pkg.sv | 68 ++++++
 rtl/test_pattern_generator_if.sv | 39 +++
 rtl/tpg_frame_ctrl.sv | 94 +++++++++
 rtl/test_pattern_generator.sv | 158 +++++++++++++++
 tb/tb_test_pattern_generator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/tpg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tpg_pkg
//  Brief    : Shared pattern/colour types and colour-code helpers for the TPG.
//  Revision : 1.0
// ============================================================================
package tpg_pkg;

    typedef enum logic [2:0] {
        PAT_HBARS = 3'd0,
        PAT_VBARS = 3'd1,
        PAT_RED   = 3'd2,
        PAT_BLUE  = 3'd3,
        PAT_RAMP  = 3'd4,
        PAT_CHECK = 3'd5,
        PAT_BAR   = 3'd6,
        PAT_BLACK = 3'd7
    } pattern_e;

    typedef enum logic [2:0] {
        COL_WHITE = 3'd0,
        COL_RED   = 3'd1,
        COL_GREEN = 3'd2,
        COL_BLUE  = 3'd3,
        COL_BLACK = 3'd4
    } colour_e;

    typedef enum logic [1:0] {
        CH_ZERO = 2'd0,
        CH_MAX  = 2'd1,
        CH_HALF = 2'd2
    } chan_e;

    // Quad order matches the Bayer output: R, Gr, Gb, B.
    typedef struct packed {
        chan_e r;
        chan_e gr;
        chan_e gb;
        chan_e b;
    } quad_code_t;

    function automatic quad_code_t colour_code(input colour_e c);
        quad_code_t q;
        q = '{CH_ZERO, CH_ZERO, CH_ZERO, CH_ZERO};
        case (c)
            COL_WHITE: q = '{CH_MAX,  CH_MAX,  CH_MAX,  CH_HALF};
            COL_RED:   q = '{CH_MAX,  CH_ZERO, CH_ZERO, CH_ZERO};
            COL_GREEN: q = '{CH_ZERO, CH_MAX,  CH_MAX,  CH_ZERO};
            COL_BLUE:  q = '{CH_ZERO, CH_ZERO, CH_ZERO, CH_MAX};
            default:   q = '{CH_ZERO, CH_ZERO, CH_ZERO, CH_ZERO};
        endcase
        return q;
    endfunction

    // Channel level for a given channel width (pw must be 1..31).
    function automatic logic [31:0] chan_level(input chan_e ch, input int unsigned pw);
        logic [31:0] lvl;
        lvl = 32'd0;
        case (ch)
            CH_MAX:  lvl = (32'd1 << pw) - 32'd1;
            CH_HALF: lvl = 32'd1 << (pw - 1);
            default: lvl = 32'd0;
        endcase
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_pattern_generator_if.sv
`default_nettype none
// ============================================================================
//  Module   : test_pattern_generator_if
//  Brief    : Raster-coordinate input and Bayer-quad output bundle of the TPG.
//  Revision : 1.0
// ============================================================================
interface test_pattern_generator_if #(
    parameter int PIXEL_WIDTH = 10,
    parameter int CNT_WIDTH   = 12
);
    logic [CNT_WIDTH-1:0]   line_number_i;
    logic [CNT_WIDTH-1:0]   hori_pixel_count_i;
    logic                   pixel_valid_i;
    logic                   auto_cycle_i;
    logic [2:0]             pattern_sel_i;

    logic [PIXEL_WIDTH-1:0] pixel_red_o;
    logic [PIXEL_WIDTH-1:0] pixel_green_red_o;
    logic [PIXEL_WIDTH-1:0] pixel_green_blue_o;
    logic [PIXEL_WIDTH-1:0] pixel_blue_o;
    logic                   pixel_valid_o;
    logic [2:0]             pattern_o;
    logic [5:0]             frame_count_o;

    modport master (
        output line_number_i, hori_pixel_count_i, pixel_valid_i,
        output auto_cycle_i, pattern_sel_i,
        input  pixel_red_o, pixel_green_red_o, pixel_green_blue_o, pixel_blue_o,
        input  pixel_valid_o, pattern_o, frame_count_o
    );

    modport slave (
        input  line_number_i, hori_pixel_count_i, pixel_valid_i,
        input  auto_cycle_i, pattern_sel_i,
        output pixel_red_o, pixel_green_red_o, pixel_green_blue_o, pixel_blue_o,
        output pixel_valid_o, pattern_o, frame_count_o
    );
endinterface
`default_nettype wire

// File: rtl/tpg_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tpg_frame_ctrl
//  Brief    : Frame-start detect, frame counter, pattern register and bar position.
//  Revision : 1.0
// ============================================================================
module tpg_frame_ctrl
    import tpg_pkg::*;
#(
    parameter int CNT_WIDTH          = 12,
    parameter int H_ACTIVE           = 2040,
    parameter int FRAMES_PER_PATTERN = 43,
    parameter int LAST_PATTERN       = 7,
    parameter int BAR_STEP           = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [CNT_WIDTH-1:0] i_line,
    input  wire logic                 i_auto_cycle,
    input  wire logic [2:0]           i_pattern_sel,
    output pattern_e                  o_pattern_eff,
    output logic [CNT_WIDTH-1:0]      o_bar_pos_eff,
    output pattern_e                  o_pattern,
    output logic [5:0]                o_frame_count
);

    localparam logic [CNT_WIDTH-1:0] c_LINE_ONE   = CNT_WIDTH'(1);
    localparam logic [5:0]           c_FC_LAST    = 6'(FRAMES_PER_PATTERN - 1);
    localparam logic [2:0]           c_PAT_LAST   = 3'(LAST_PATTERN);
    localparam logic [CNT_WIDTH:0]   c_H_WIDE     = (CNT_WIDTH+1)'(H_ACTIVE);
    localparam logic [CNT_WIDTH:0]   c_STEP_WIDE  = (CNT_WIDTH+1)'(BAR_STEP);
    localparam logic [CNT_WIDTH-1:0] c_H_NARROW   = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] c_STEP_NARROW = CNT_WIDTH'(BAR_STEP);

    logic [CNT_WIDTH-1:0] r_prev_line;
    logic                 r_fs_s1;
    logic [5:0]           r_frame_count;
    pattern_e             r_pattern;
    logic [CNT_WIDTH-1:0] r_bar_pos;

    logic                 w_fc_wrap;
    logic [5:0]           w_fc_next;
    pattern_e             w_pattern_next;
    logic [CNT_WIDTH:0]   w_bar_sum;
    logic                 w_bar_ovf;
    logic [CNT_WIDTH-1:0] w_bar_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_line   <= '0;
            r_fs_s1       <= 1'b0;
            r_frame_count <= '0;
            r_pattern     <= PAT_HBARS;
            r_bar_pos     <= '0;
        end else begin
            r_prev_line   <= i_line;
            r_fs_s1       <= (i_line == c_LINE_ONE) && (r_prev_line != c_LINE_ONE);
            r_frame_count <= w_fc_next;
            r_pattern     <= w_pattern_next;
            r_bar_pos     <= w_bar_next;
        end
    end

    // Bar position stays below H_ACTIVE, so the wrapped result fits CNT_WIDTH bits.
    assign w_bar_sum = {1'b0, r_bar_pos} + c_STEP_WIDE;
    assign w_bar_ovf = (w_bar_sum >= c_H_WIDE);
    assign w_fc_wrap = (r_frame_count == c_FC_LAST);

    always_comb begin
        w_fc_next      = r_frame_count;
        w_pattern_next = r_pattern;
        w_bar_next     = r_bar_pos;
        if (r_fs_s1) begin
            w_fc_next  = w_fc_wrap ? 6'd0 : r_frame_count + 6'd1;
            w_bar_next = r_bar_pos + c_STEP_NARROW - (w_bar_ovf ? c_H_NARROW : '0);
            if (i_auto_cycle) begin
                if (w_fc_wrap) begin
                    w_pattern_next = (r_pattern == c_PAT_LAST) ? PAT_HBARS
                                                               : pattern_e'(r_pattern + 3'd1);
                end
            end else begin
                w_pattern_next = pattern_e'(i_pattern_sel);
            end
        end
    end

    // The frame-start pixel is coloured with the values being loaded this cycle.
    assign o_pattern_eff = w_pattern_next;
    assign o_bar_pos_eff = w_bar_next;
    assign o_pattern     = r_pattern;
    assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: rtl/test_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module   : test_pattern_generator
//  Brief    : Eight-mode Bayer test pattern generator, two-stage pipeline.
//  Revision : 1.0
// ============================================================================
module test_pattern_generator
    import tpg_pkg::*;
#(
    parameter int PIXEL_WIDTH        = 10,
    parameter int CNT_WIDTH          = 12,
    parameter int H_ACTIVE           = 2040,
    parameter int V_ACTIVE           = 2464,
    parameter int FRAMES_PER_PATTERN = 43,
    parameter int LAST_PATTERN       = 7,
    parameter int RAMP_SHIFT         = 1,
    parameter int CHECK_LOG2         = 6,
    parameter int BAR_WIDTH          = 255,
    parameter int BAR_STEP           = 16
) (
    input  wire logic                  byte_clk_i,
    input  wire logic                  reset_i,
    test_pattern_generator_if.slave    bus
);

    localparam logic [PIXEL_WIDTH-1:0] c_MAX  = PIXEL_WIDTH'(chan_level(CH_MAX, PIXEL_WIDTH));
    localparam logic [PIXEL_WIDTH-1:0] c_HALF = PIXEL_WIDTH'(chan_level(CH_HALF, PIXEL_WIDTH));
    localparam logic [CNT_WIDTH-1:0]   c_VQ1  = CNT_WIDTH'(V_ACTIVE / 4);
    localparam logic [CNT_WIDTH-1:0]   c_VQ2  = CNT_WIDTH'(2 * (V_ACTIVE / 4));
    localparam logic [CNT_WIDTH-1:0]   c_VQ3  = CNT_WIDTH'(3 * (V_ACTIVE / 4));
    localparam logic [CNT_WIDTH-1:0]   c_HQ1  = CNT_WIDTH'(H_ACTIVE / 4);
    localparam logic [CNT_WIDTH-1:0]   c_HQ2  = CNT_WIDTH'(2 * (H_ACTIVE / 4));
    localparam logic [CNT_WIDTH-1:0]   c_HQ3  = CNT_WIDTH'(3 * (H_ACTIVE / 4));
    localparam logic [CNT_WIDTH:0]     c_BAR_WIDTH = (CNT_WIDTH+1)'(BAR_WIDTH);

    function automatic colour_e bar_colour(
        input logic [CNT_WIDTH-1:0] v,
        input logic [CNT_WIDTH-1:0] q1,
        input logic [CNT_WIDTH-1:0] q2,
        input logic [CNT_WIDTH-1:0] q3
    );
        if (v >= q3)      return COL_RED;
        else if (v >= q2) return COL_BLUE;
        else if (v >= q1) return COL_GREEN;
        else              return COL_WHITE;
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] level(input chan_e ch);
        case (ch)
            CH_MAX:  return c_MAX;
            CH_HALF: return c_HALF;
            default: return '0;
        endcase
    endfunction

    logic [CNT_WIDTH-1:0]   r_line_s1;
    logic [CNT_WIDTH-1:0]   r_pix_s1;
    logic                   r_valid_s1;
    logic                   r_valid_o;
    logic [PIXEL_WIDTH-1:0] r_red;
    logic [PIXEL_WIDTH-1:0] r_green_red;
    logic [PIXEL_WIDTH-1:0] r_green_blue;
    logic [PIXEL_WIDTH-1:0] r_blue;

    pattern_e               w_pattern_eff;
    pattern_e               w_pattern;
    logic [CNT_WIDTH-1:0]   w_bar_pos;
    logic [5:0]             w_frame_count;
    logic [CNT_WIDTH:0]     w_bar_end;
    logic                   w_in_bar;
    colour_e                w_colour;
    logic                   w_use_ramp;
    quad_code_t             w_code;
    logic [PIXEL_WIDTH-1:0] w_ramp;
    logic [PIXEL_WIDTH-1:0] w_red;
    logic [PIXEL_WIDTH-1:0] w_green_red;
    logic [PIXEL_WIDTH-1:0] w_green_blue;
    logic [PIXEL_WIDTH-1:0] w_blue;

    tpg_frame_ctrl #(
        .CNT_WIDTH          (CNT_WIDTH),
        .H_ACTIVE           (H_ACTIVE),
        .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN),
        .LAST_PATTERN       (LAST_PATTERN),
        .BAR_STEP           (BAR_STEP)
    ) u_frame_ctrl (
        .clk            (byte_clk_i),
        .rst_n          (reset_i),
        .i_line         (bus.line_number_i),
        .i_auto_cycle   (bus.auto_cycle_i),
        .i_pattern_sel  (bus.pattern_sel_i),
        .o_pattern_eff  (w_pattern_eff),
        .o_bar_pos_eff  (w_bar_pos),
        .o_pattern      (w_pattern),
        .o_frame_count  (w_frame_count)
    );

    // The bar end is one bit wider so the bar clips instead of wrapping.
    assign w_bar_end = {1'b0, w_bar_pos} + c_BAR_WIDTH;
    assign w_in_bar  = (r_pix_s1 >= w_bar_pos) && ({1'b0, r_pix_s1} < w_bar_end);
    assign w_ramp    = PIXEL_WIDTH'(r_pix_s1 >> RAMP_SHIFT);

    always_comb begin
        w_colour   = COL_BLACK;
        w_use_ramp = 1'b0;
        case (w_pattern_eff)
            PAT_HBARS: w_colour = bar_colour(r_line_s1, c_VQ1, c_VQ2, c_VQ3);
            PAT_VBARS: w_colour = bar_colour(r_pix_s1, c_HQ1, c_HQ2, c_HQ3);
            PAT_RED:   w_colour = COL_RED;
            PAT_BLUE:  w_colour = COL_BLUE;
            PAT_RAMP:  w_use_ramp = 1'b1;
            PAT_CHECK: w_colour = (r_line_s1[CHECK_LOG2] ^ r_pix_s1[CHECK_LOG2]) ? COL_WHITE
                                                                                  : COL_BLACK;
            PAT_BAR:   w_colour = w_in_bar ? COL_WHITE : COL_BLACK;
            default:   w_colour = COL_BLACK;
        endcase
    end

    assign w_code       = colour_code(w_colour);
    assign w_red        = w_use_ramp ? w_ramp : level(w_code.r);
    assign w_green_red  = w_use_ramp ? w_ramp : level(w_code.gr);
    assign w_green_blue = w_use_ramp ? w_ramp : level(w_code.gb);
    assign w_blue       = w_use_ramp ? w_ramp : level(w_code.b);

    always_ff @(posedge byte_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_line_s1    <= '0;
            r_pix_s1     <= '0;
            r_valid_s1   <= 1'b0;
            r_valid_o    <= 1'b0;
            r_red        <= '0;
            r_green_red  <= '0;
            r_green_blue <= '0;
            r_blue       <= '0;
        end else begin
            r_line_s1  <= bus.line_number_i;
            r_pix_s1   <= bus.hori_pixel_count_i;
            r_valid_s1 <= bus.pixel_valid_i;
            r_valid_o  <= r_valid_s1;
            if (r_valid_s1) begin
                r_red        <= w_red;
                r_green_red  <= w_green_red;
                r_green_blue <= w_green_blue;
                r_blue       <= w_blue;
            end
        end
    end

    assign bus.pixel_red_o        = r_red;
    assign bus.pixel_green_red_o  = r_green_red;
    assign bus.pixel_green_blue_o = r_green_blue;
    assign bus.pixel_blue_o       = r_blue;
    assign bus.pixel_valid_o      = r_valid_o;
    assign bus.pattern_o          = w_pattern;
    assign bus.frame_count_o      = w_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test_pattern_generator
//  Brief    : Directed self-checking bench for test_pattern_generator.
//  Revision : 1.0
// ============================================================================
module tb_test_pattern_generator;

    localparam int PW = 10;
    localparam int CW = 12;
    localparam logic [9:0]  c_MX = 10'h3FF;
    localparam logic [9:0]  c_HF = 10'h200;
    localparam logic [39:0] c_WHITE = {c_MX, c_MX, c_MX, c_HF};
    localparam logic [39:0] c_RED   = {c_MX, 10'd0, 10'd0, 10'd0};
    localparam logic [39:0] c_GREEN = {10'd0, c_MX, c_MX, 10'd0};
    localparam logic [39:0] c_BLUE  = {10'd0, 10'd0, 10'd0, c_MX};
    localparam logic [39:0] c_BLACK = 40'd0;

    typedef struct {
        logic [2:0]  pat;
        int          line;
        int          pix;
        logic [39:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[22];
    logic [39:0] act_quad;

    test_pattern_generator_if #(.PIXEL_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    test_pattern_generator #(
        .PIXEL_WIDTH(PW), .CNT_WIDTH(CW), .H_ACTIVE(2040), .V_ACTIVE(2464),
        .FRAMES_PER_PATTERN(43), .LAST_PATTERN(7), .RAMP_SHIFT(1),
        .CHECK_LOG2(6), .BAR_WIDTH(255), .BAR_STEP(16)
    ) dut (
        .byte_clk_i (clk),
        .reset_i    (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign act_quad = {bus.pixel_red_o, bus.pixel_green_red_o,
                       bus.pixel_green_blue_o, bus.pixel_blue_o};

    function automatic logic [39:0] grey(input logic [9:0] v);
        return {v, v, v, v};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int l, input int p, input logic v);
        bus.line_number_i      = CW'(l);
        bus.hori_pixel_count_i = CW'(p);
        bus.pixel_valid_i      = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        push(2, 0, 1'b0);
        push(1, 0, 1'b0);
        push(1, 0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " quad"}, act_quad, c_BLACK);
        chk({tag, " valid"}, 40'(bus.pixel_valid_o), 40'd0);
        chk({tag, " pattern"}, 40'(bus.pattern_o), 40'd0);
        chk({tag, " fcount"}, 40'(bus.frame_count_o), 40'd0);
    endtask

    // Asynchronous assert between edges, release away from the edge.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int eb;
        int offs[5];
        logic [39:0] oexp[5];

        bus.line_number_i      = '0;
        bus.hori_pixel_count_i = '0;
        bus.pixel_valid_i      = 1'b0;
        bus.auto_cycle_i       = 1'b1;
        bus.pattern_sel_i      = 3'd0;

        vecs[0]  = '{3'd1, 10, 509,  c_WHITE};
        vecs[1]  = '{3'd1, 10, 510,  c_GREEN};
        vecs[2]  = '{3'd1, 10, 1019, c_GREEN};
        vecs[3]  = '{3'd1, 10, 1020, c_BLUE};
        vecs[4]  = '{3'd1, 10, 1529, c_BLUE};
        vecs[5]  = '{3'd1, 10, 1530, c_RED};
        vecs[6]  = '{3'd0, 615, 0,   c_WHITE};
        vecs[7]  = '{3'd0, 616, 0,   c_GREEN};
        vecs[8]  = '{3'd0, 1231, 0,  c_GREEN};
        vecs[9]  = '{3'd0, 1232, 0,  c_BLUE};
        vecs[10] = '{3'd0, 1848, 0,  c_RED};
        vecs[11] = '{3'd0, 4000, 0,  c_RED};
        vecs[12] = '{3'd2, 7, 9,     c_RED};
        vecs[13] = '{3'd3, 7, 9,     c_BLUE};
        vecs[14] = '{3'd7, 7, 9,     c_BLACK};
        vecs[15] = '{3'd4, 3, 100,   grey(10'd50)};
        vecs[16] = '{3'd4, 3, 3000,  grey(10'h1DC)};
        vecs[17] = '{3'd5, 64, 0,    c_WHITE};
        vecs[18] = '{3'd5, 64, 64,   c_BLACK};
        vecs[19] = '{3'd5, 1, 63,    c_BLACK};
        vecs[20] = '{3'd5, 1, 64,    c_WHITE};
        vecs[21] = '{3'd1, 10, 4095, c_RED};

        // Reset state, then first line-1 entry.
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        push(1, 0, 1'b1);
        push(1, 1, 1'b1);
        chk("first quad", act_quad, c_WHITE);
        chk("first valid", 40'(bus.pixel_valid_o), 40'd1);
        chk("first fcount", 40'(bus.frame_count_o), 40'd1);
        chk("first pattern", 40'(bus.pattern_o), 40'd0);

        // Auto-cycle: 43 frame starts per pattern, 7 wraps to 0.
        repeat (41) do_frame();
        chk("auto f42 pattern", 40'(bus.pattern_o), 40'd0);
        chk("auto f42 fcount", 40'(bus.frame_count_o), 40'd42);
        do_frame();
        chk("auto f43 pattern", 40'(bus.pattern_o), 40'd1);
        chk("auto f43 fcount", 40'(bus.frame_count_o), 40'd0);
        repeat (300) do_frame();
        chk("auto f343 pattern", 40'(bus.pattern_o), 40'd7);
        chk("auto f343 fcount", 40'(bus.frame_count_o), 40'd42);
        do_frame();
        chk("auto f344 pattern", 40'(bus.pattern_o), 40'd0);
        chk("auto f344 fcount", 40'(bus.frame_count_o), 40'd0);

        // Vector table in host-select mode.
        bus.auto_cycle_i = 1'b0;
        for (int i = 0; i < 22; i++) begin
            bus.pattern_sel_i = vecs[i].pat;
            push(5, 0, 1'b0);
            push(1, 0, 1'b0);
            push(vecs[i].line, vecs[i].pix, 1'b1);
            push(vecs[i].line, 0, 1'b0);
            chk($sformatf("vec%0d quad", i), act_quad, vecs[i].exp);
            chk($sformatf("vec%0d pattern", i), 40'(bus.pattern_o), 40'(vecs[i].pat));
        end

        // Two-cycle latency and hold when idle.
        bus.pattern_sel_i = 3'd1;
        do_frame();
        push(10, 509, 1'b1);
        chk("lat edge1 valid", 40'(bus.pixel_valid_o), 40'd0);
        push(10, 0, 1'b0);
        chk("lat edge2 valid", 40'(bus.pixel_valid_o), 40'd1);
        chk("lat edge2 quad", act_quad, c_WHITE);
        push(10, 0, 1'b0);
        chk("lat edge3 valid", 40'(bus.pixel_valid_o), 40'd0);
        chk("lat edge3 hold", act_quad, c_WHITE);

        // Mid-frame select change takes effect at the next frame start.
        bus.pattern_sel_i = 3'd4;
        do_frame();
        push(3, 100, 1'b1);
        push(3, 0, 1'b0);
        chk("sel ramp quad", act_quad, grey(10'd50));
        bus.pattern_sel_i = 3'd5;
        push(5, 100, 1'b1);
        push(5, 0, 1'b0);
        chk("sel midframe quad", act_quad, grey(10'd50));
        chk("sel midframe pattern", 40'(bus.pattern_o), 40'd4);
        push(2, 0, 1'b0);
        push(1, 64, 1'b1);
        push(1, 0, 1'b0);
        chk("sel fs quad", act_quad, c_WHITE);
        chk("sel fs pattern", 40'(bus.pattern_o), 40'd5);

        // Reset while line 1 is held, then held line 1 with valid gaps.
        bus.pattern_sel_i = 3'd4;
        push(1, 0, 1'b0);
        do_reset("midline reset");
        push(1, 10, 1'b1);
        push(1, 0, 1'b0);
        chk("hold fs fcount", 40'(bus.frame_count_o), 40'd1);
        chk("hold fs pattern", 40'(bus.pattern_o), 40'd4);
        chk("hold fs quad", act_quad, grey(10'd5));
        chk("hold fs valid", 40'(bus.pixel_valid_o), 40'd1);
        push(1, 0, 1'b0);
        chk("gap valid", 40'(bus.pixel_valid_o), 40'd0);
        chk("gap quad", act_quad, grey(10'd5));
        for (int i = 0; i < 12; i++) push(1, 20 + i, (i % 3) == 0);
        push(1, 0, 1'b0);
        push(1, 0, 1'b0);
        chk("held line quad", act_quad, grey(10'd14));
        chk("held line fcount", 40'(bus.frame_count_o), 40'd1);
        do_frame();
        chk("next fs fcount", 40'(bus.frame_count_o), 40'd2);

        // Moving bar over 128 frames from a fresh reset.
        do_reset("bar reset");
        bus.pattern_sel_i = 3'd6;
        offs = '{0, -1, 7, 254, 255};
        oexp = '{c_WHITE, c_BLACK, c_WHITE, c_WHITE, c_BLACK};
        eb = 0;
        for (int k = 1; k <= 128; k++) begin
            do_frame();
            eb = eb + 16;
            if (eb >= 2040) eb = eb - 2040;
            for (int j = 0; j < 5; j++) begin
                push(1, eb + offs[j], 1'b1);
                push(1, 0, 1'b0);
                chk($sformatf("bar f%0d pos%0d P%0d", k, eb, eb + offs[j]), act_quad, oexp[j]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
